// File: rtl/sma_truth_table_sequencer_if.sv
// Operand/result/write-port bundle between the truth-table sequencer,
// the external sign-magnitude adder and the truth-table memory.
interface sma_truth_table_sequencer_if #(
    parameter int DATA_WIDTH = 2
);
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic                    op_valid;
    logic [DATA_WIDTH:0]     sum_in;
    logic                    wr_en;
    logic [2*DATA_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH:0]     wr_data;

    modport master (
        output op_a,
        output op_b,
        output op_valid,
        input  sum_in,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  op_valid,
        output sum_in,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/sma_truth_table_sequencer.sv
// Sweeps every {a,b} operand pair through a fixed-latency adder and writes each
// sum to the truth-table memory at address {a,b}; reports completion or abort.
module sma_truth_table_sequencer #(
    parameter int DATA_WIDTH  = 2,
    parameter int ADD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    sma_truth_table_sequencer_if.master bus,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_aborted,
    output logic [2*DATA_WIDTH:0]     o_wr_count
);
    localparam int AW = 2 * DATA_WIDTH;
    localparam logic [AW-1:0] LAST_ENTRY = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [AW-1:0]                    r_cnt;
    logic [ADD_LATENCY-1:0]           r_vld;
    logic [ADD_LATENCY-1:0][AW-1:0]   r_tag;
    logic [ADD_LATENCY-1:0]           w_vld_next;
    logic [ADD_LATENCY-1:0][AW-1:0]   w_tag_next;
    logic                             r_aborted;
    logic [AW:0]                      r_wr_count;

    logic w_push;
    logic w_flush;
    logic w_accept_start;
    logic w_pipe_empty;
    logic w_out_vld;

    // Stage 0 is the newest entry; stage ADD_LATENCY-1 lines up with sum_in.
    genvar gi;
    generate
        for (gi = 0; gi < ADD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_vld_next[gi] = w_push;
                assign w_tag_next[gi] = r_cnt;
            end else begin : g_body
                assign w_vld_next[gi] = r_vld[gi-1];
                assign w_tag_next[gi] = r_tag[gi-1];
            end
        end
    endgenerate

    // Draining ends once only the oldest stage (being written now) can be live.
    assign w_pipe_empty = ((r_vld << 1) == '0);
    assign w_out_vld    = r_vld[ADD_LATENCY-1];

    always_comb begin
        w_state_next   = r_state;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        w_accept_start = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_accept_start = 1'b1;
                    w_state_next   = S_SWEEP;
                end
            end
            S_SWEEP: begin
                bus.op_valid = 1'b1;
                bus.op_a     = r_cnt[AW-1:DATA_WIDTH];
                bus.op_b     = r_cnt[DATA_WIDTH-1:0];
                o_busy       = 1'b1;
                if (i_abort) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_push = 1'b1;
                    if (r_cnt == LAST_ENTRY) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_pipe_empty) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The counter wraps to zero as the terminal entry issues, so it is only
    // explicitly cleared on start (an abort can leave it mid-sweep).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept_start) begin
            r_cnt <= '0;
        end else if (r_state == S_SWEEP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_vld <= w_vld_next;
            r_tag <= w_tag_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_aborted <= w_flush;
            if (w_accept_start) begin
                r_wr_count <= '0;
            end else if (w_out_vld) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    assign bus.wr_en   = w_out_vld;
    assign bus.wr_addr = w_out_vld ? r_tag[ADD_LATENCY-1] : '0;
    assign bus.wr_data = w_out_vld ? bus.sum_in : '0;
    assign o_aborted   = r_aborted;
    assign o_wr_count  = r_wr_count;
endmodule

// File: tb/tb_sma_truth_table_sequencer.sv
// Scoreboard bench for the truth-table sequencer with a behavioural
// two-cycle sign-magnitude adder on the operand/result bus.
module tb_sma_truth_table_sequencer;
    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [4:0] wr_count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_count = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;
    exp_t exp_q[$];

    sma_truth_table_sequencer_if #(.DATA_WIDTH(W)) bus ();

    sma_truth_table_sequencer #(.DATA_WIDTH(W), .ADD_LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start),
        .i_abort    (abort),
        .bus        (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_aborted  (aborted),
        .o_wr_count (wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sign-magnitude value of a 2-bit operand, summed and re-encoded in 3 bits.
    function automatic int ref_sum(input int a, input int b);
        int va, vb, s;
        va = (a >= 2) ? -(a - 2) : a;
        vb = (b >= 2) ? -(b - 2) : b;
        s  = va + vb;
        return (s < 0) ? (4 - s) : s;
    endfunction

    logic [2:0] add_p1 = 3'd0;
    logic [2:0] add_p2 = 3'd0;
    always @(posedge clk) begin
        add_p1 <= 3'(ref_sum(int'(bus.op_a), int'(bus.op_b)));
        add_p2 <= add_p1;
    end
    assign bus.sum_in = add_p2;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the next expected entry.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(bus.wr_addr), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", int'(bus.wr_addr), e.addr);
                check("wr_data", int'(bus.wr_data), e.data);
                $display("write cycle %0d addr %0d data %0d", cyc, bus.wr_addr, bus.wr_data);
            end
        end
    end

    function automatic int all_outputs();
        return int'({bus.op_valid, bus.op_a, bus.op_b, bus.wr_en, bus.wr_addr,
                     bus.wr_data, busy, done, aborted, wr_count});
    endfunction

    // One start pulse at rel cycle 0, with optional abort / second start / reset.
    task automatic run_case(input int abort_at, input int restart_at, input int reset_at);
        int t0, stop_at, nw, exp_opv, n_opv, n_done, done_rel, busy_done;
        int n_abt, abt_rel, busy_abt, exp_done, exp_abt, exp_cnt;
        exp_t e;
        t0 = cyc;
        stop_at = -1;
        if (abort_at >= 1 && abort_at <= 18) stop_at = abort_at;
        if (reset_at >= 1) stop_at = reset_at;
        if (abort_at == 0) begin
            nw = 0;
            exp_opv = 0;
        end else if (stop_at > 0) begin
            nw = (stop_at - 2 < 0) ? 0 : ((stop_at - 2 > 16) ? 16 : stop_at - 2);
            exp_opv = (stop_at > 16) ? 16 : stop_at;
        end else begin
            nw = 16;
            exp_opv = 16;
        end
        for (int i = 0; i < nw; i++) begin
            e.cyc  = t0 + 3 + i;
            e.addr = i;
            e.data = ref_sum(i / 4, i % 4);
            exp_q.push_back(e);
        end
        exp_done = (abort_at != 0 && stop_at < 0) ? 1 : 0;
        exp_abt  = (reset_at < 0 && abort_at >= 1 && abort_at <= 18) ? 1 : 0;
        if (reset_at >= 1) exp_cnt = 0;
        else if (abort_at == 0) exp_cnt = last_count;
        else exp_cnt = nw;

        n_opv = 0; n_done = 0; done_rel = -1; busy_done = -1;
        n_abt = 0; abt_rel = -1; busy_abt = -1;
        for (int rel = 0; rel < 26; rel++) begin
            start = (rel == 0) || (rel == restart_at);
            abort = (rel == abort_at);
            reset = (rel == reset_at);
            @(negedge clk);
            if (bus.op_valid) begin
                n_opv++;
                check("op_ab", int'({bus.op_a, bus.op_b}), rel - 1);
            end
            if (done) begin
                n_done++; done_rel = rel; busy_done = int'(busy);
            end
            if (aborted) begin
                n_abt++; abt_rel = rel; busy_abt = int'(busy);
            end
            if (reset_at >= 0 && rel == reset_at + 1)
                check("outputs_after_reset", all_outputs(), 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;

        check("op_valid_cycles", n_opv, exp_opv);
        check("done_pulses", n_done, exp_done);
        if (exp_done == 1) begin
            check("done_cycle", done_rel, 19);
            check("busy_at_done", busy_done, 0);
        end
        check("aborted_pulses", n_abt, exp_abt);
        if (exp_abt == 1) begin
            check("aborted_cycle", abt_rel, abort_at + 1);
            check("busy_at_aborted", busy_abt, 0);
        end
        check("wr_count", int'(wr_count), exp_cnt);
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        last_count = exp_cnt;
        $display("case abort=%0d restart=%0d reset=%0d writes=%0d wr_count=%0d done=%0d aborted=%0d",
                 abort_at, restart_at, reset_at, nw, wr_count, n_done, n_abt);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_case(-1, -1, -1);
        run_case(6, -1, -1);
        run_case(-1, 10, -1);
        run_case(0, -1, -1);
        run_case(-1, -1, 8);
        run_case(-1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            run_case(int'($urandom_range(1, 20)), -1, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
